// File: rtl/n_bit_mux_pkg.sv
// Shared select-code constants for the n-bit 4-to-1 word multiplexer.
package n_bit_mux_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

endpackage : n_bit_mux_pkg

// File: rtl/mux4_core.sv
// Purely combinational 4-to-1 word selector; S picks one of A/B/C/D.
module mux4_core
    import n_bit_mux_pkg::*;
#(
    parameter int n = 4
) (
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [n-1:0] C,
    input  logic [n-1:0] D,
    input  logic [1:0]   S,
    output logic [n-1:0] sel
);

    // Word steering; an unknown select falls through to X so simulation exposes it.
    always_comb begin
        sel = 'x;
        case (S)
            SEL_A: sel = A;
            SEL_B: sel = B;
            SEL_C: sel = C;
            SEL_D: sel = D;
        endcase
    end

endmodule : mux4_core

// File: rtl/n_bit_4x1_multiplexer.sv
// n-bit 4-to-1 multiplexer with a registered output and a loaded-since-reset flag.
module n_bit_4x1_multiplexer
    import n_bit_mux_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [n-1:0] C,
    input  logic [n-1:0] D,
    input  logic [1:0]   S,
    output logic [n-1:0] Y,
    output logic         y_valid
);

    logic [n-1:0] sel;

    mux4_core #(
        .n(n)
    ) u_core (
        .A  (A),
        .B  (B),
        .C  (C),
        .D  (D),
        .S  (S),
        .sel(sel)
    );

    // Output register: reset wins over data, otherwise capture the selection every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y       <= '0;
            y_valid <= 1'b0;
        end else begin
            Y       <= sel;
            y_valid <= 1'b1;
        end
    end

endmodule : n_bit_4x1_multiplexer

// File: tb/tb_n_bit_4x1_multiplexer.sv
// Directed bench for the registered 4-to-1 multiplexer at widths 4, 16 and 1.
module tb_n_bit_4x1_multiplexer;
    import n_bit_mux_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  S;

    logic [3:0]  a4, b4, c4, d4, y4;
    logic        v4;
    logic [15:0] a16, b16, c16, d16, y16;
    logic        v16;
    logic [0:0]  a1, b1, c1, d1, y1;
    logic        v1;

    int compare_count;
    int fail_count;

    n_bit_4x1_multiplexer #(.n(4)) dut4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .C(c4), .D(d4), .S(S),
        .Y(y4), .y_valid(v4)
    );

    n_bit_4x1_multiplexer #(.n(16)) dut16 (
        .clk(clk), .rst(rst), .A(a16), .B(b16), .C(c16), .D(d16), .S(S),
        .Y(y16), .y_valid(v16)
    );

    n_bit_4x1_multiplexer #(.n(1)) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .C(c1), .D(d1), .S(S),
        .Y(y1), .y_valid(v1)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point; values are zero-extended to 16 bits for reporting.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compare_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Check all three widths after a select edge.
    task automatic checkAll(input string tag, input logic [3:0] e4,
                            input logic [15:0] e16, input logic e1, input logic ev);
        checkOutput({tag, "_y4"},  {12'h000, y4},  {12'h000, e4});
        checkOutput({tag, "_y16"}, y16,            e16);
        checkOutput({tag, "_y1"},  {15'h0000, y1}, {15'h0000, e1});
        checkOutput({tag, "_v4"},  {15'h0000, v4},  {15'h0000, ev});
        checkOutput({tag, "_v16"}, {15'h0000, v16}, {15'h0000, ev});
        checkOutput({tag, "_v1"},  {15'h0000, v1},  {15'h0000, ev});
    endtask

    initial begin
        compare_count = 0;
        fail_count    = 0;

        rst = 1'b1;
        S   = SEL_D;
        a4  = 4'b1010;     b4  = 4'b0110;     c4  = 4'b1101;     d4  = 4'b0001;
        a16 = 16'hA5A5;    b16 = 16'h5A5A;    c16 = 16'hFFFF;    d16 = 16'h0000;
        a1  = 1'b1;        b1  = 1'b0;        c1  = 1'b1;        d1  = 1'b0;

        // Reset held for two edges with S=11 / D=0001 on the inputs.
        applyStimulus();
        checkAll("reset_edge1", 4'b0000, 16'h0000, 1'b0, 1'b0);
        applyStimulus();
        checkAll("reset_edge2", 4'b0000, 16'h0000, 1'b0, 1'b0);

        // Select each input on successive edges.
        rst = 1'b0;
        S   = SEL_A;
        applyStimulus();
        checkAll("sel_a", 4'b1010, 16'hA5A5, 1'b1, 1'b1);
        S = SEL_B;
        applyStimulus();
        checkAll("sel_b", 4'b0110, 16'h5A5A, 1'b0, 1'b1);
        S = SEL_C;
        applyStimulus();
        checkAll("sel_c", 4'b1101, 16'hFFFF, 1'b1, 1'b1);
        S = SEL_D;
        applyStimulus();
        checkAll("sel_d", 4'b0001, 16'h0000, 1'b0, 1'b1);

        // Latency: a select change between edges must not reach Y until the next edge.
        S = SEL_A;
        applyStimulus();
        checkOutput("lat_before", {12'h000, y4}, 16'h000A);
        S = SEL_C;
        #3;
        checkOutput("lat_mid", {12'h000, y4}, 16'h000A);
        applyStimulus();
        checkOutput("lat_after", {12'h000, y4}, 16'h000D);

        // Mid-stream reset while Y=1101, then reload with S=11.
        rst = 1'b1;
        applyStimulus();
        checkAll("mid_rst", 4'b0000, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        S   = SEL_D;
        applyStimulus();
        checkAll("post_rst", 4'b0001, 16'h0000, 1'b0, 1'b1);

        // Data stepping on B with select fixed at 01.
        S  = SEL_B;
        b4 = 4'b0110;
        applyStimulus();
        checkOutput("data_b0", {12'h000, y4}, 16'h0006);
        b4 = 4'b1111;
        #3;
        checkOutput("data_b1_mid", {12'h000, y4}, 16'h0006);
        applyStimulus();
        checkOutput("data_b1", {12'h000, y4}, 16'h000F);
        b4 = 4'b0000;
        applyStimulus();
        checkOutput("data_b2", {12'h000, y4}, 16'h0000);

        // Rapid select toggling across widths with fresh data.
        a16 = 16'h1234; c16 = 16'h8001;
        S = SEL_C;
        applyStimulus();
        checkAll("tog_c", 4'b1101, 16'h8001, 1'b1, 1'b1);
        S = SEL_A;
        applyStimulus();
        checkAll("tog_a", 4'b1010, 16'h1234, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule : tb_n_bit_4x1_multiplexer
